// File: rtl/dps_enc_arbiter.sv
// dps_enc_arbiter: round-robin front end for a shared, registered DPS (FNS)
// encoder. Accepted words travel through a two-stage tag pipeline that
// tracks the encoder latency, then land in a small first-word-fall-through
// result FIFO tagged with the originating requester index.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// exactly when valid and ready are both high in the cycle before that edge.
// valid never depends on ready; req_ready is combinational from req_valid and
// registered occupancy; out_valid is purely registered.

`ifndef DBLEN33
`define DBLEN33 24
`endif
`ifndef FNS35
`define FNS35 24'd9227465
`endif

module dps_enc_arbiter #(
    parameter int            NREQ   = 4,
    parameter int            DW     = `DBLEN33,
    parameter int            CW     = 33,
    parameter int            DEPTH  = 4,
    parameter logic [DW-1:0] MAXVAL = `FNS35
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [DW-1:0]            enc_datain,
    input  logic [CW-1:0]            enc_codeout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_code,
    output logic [$clog2(NREQ)-1:0]  out_id,
    output logic                     err_range,
    input  logic                     err_clr
);

    localparam int IW   = $clog2(NREQ);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int OW   = AW + 2;
    localparam int EW   = CW + IW;

    // Registered state
    logic [IW-1:0]   rr_ptr_q,     rr_ptr_d;
    logic [DW-1:0]   enc_datain_q, enc_datain_d;
    logic            s1_valid_q,   s1_valid_d;
    logic [IW-1:0]   s1_id_q,      s1_id_d;
    logic            s2_valid_q,   s2_valid_d;
    logic [IW-1:0]   s2_id_q,      s2_id_d;
    logic            err_q,        err_d;
    logic [AW-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [CNTW-1:0] cnt_q,        cnt_d;
    logic [EW-1:0]   mem_q [DEPTH];

    // Combinational helpers
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [OW-1:0]   occupancy;
    logic            credit;
    logic            accept;
    logic [DW-1:0]   acc_data;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;

    // Round-robin search, starting one past the last granted requester
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    // Credit covers both in-flight stages so a FIFO push can never overflow
    always_comb begin
        occupancy = OW'(cnt_q) + OW'(s1_valid_q) + OW'(s2_valid_q);
        credit    = (occupancy < OW'(DEPTH));
        req_ready = '0;
        if (rst_n && grant_found && credit) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign acc_data = req_data[grant_idx*DW +: DW];

    // Accept path, tag pipeline and sticky range error (a new error wins over clear)
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        enc_datain_d = enc_datain_q;
        s1_valid_d   = 1'b0;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s1_valid_q;
        s2_id_d      = s1_id_q;
        err_d        = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (accept) begin
            rr_ptr_d     = grant_idx;
            enc_datain_d = acc_data;
            s1_id_d      = grant_idx;
            if (acc_data < MAXVAL) begin
                s1_valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign push      = s2_valid_q;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= IW'(NREQ - 1);
            enc_datain_q <= '0;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_id_q      <= '0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            enc_datain_q <= enc_datain_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_id_q      <= s2_id_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // FIFO storage: stage-2 tag pairs with the code the encoder registered
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {enc_codeout, s2_id_q};
        end
    end

    assign enc_datain = enc_datain_q;
    assign err_range  = err_q;
    assign out_code   = out_valid ? head[EW-1:IW] : '0;
    assign out_id     = out_valid ? head[IW-1:0]  : '0;

endmodule
